// File: rtl/uart_pkg.sv
// Shared types and register map constants for the LSU-attached UART transmitter.
package uart_pkg;

  // Transmit FSM states
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Word offsets within the 16-byte register window (addr[3:2])
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  // STATUS register bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [7:0]                 wdata_i,
  output logic [7:0]                 rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot being written when full
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lsu_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the LSU port: TXDATA pushes into a FIFO,
// STATUS/CTRL are polled with loads, and queued bytes are sent LSB first.
module lsu_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_7040,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic        uart_tx_o,
  output logic        tx_done_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned FcW  = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic       sel;
  logic [1:0] off;
  logic       push_req, push_acc;

  // FIFO interface
  logic           fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata;
  logic [FcW-1:0] fifo_count;

  // Registers
  logic            en_q, en_d;
  logic            ovf_q, ovf_d;
  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_last;

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], st_data_i[31:8]};

  assign sel      = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign off      = addr_i[3:2];
  assign push_req = st_en_i && sel && (off == OFF_TXDATA);
  assign push_acc = push_req && (!fifo_full || fifo_pop);
  assign bit_last = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_acc),
    .pop_i   (fifo_pop),
    .wdata_i (st_data_i[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // CTRL enable and sticky overflow next-state
  always_comb begin
    en_d  = en_q;
    ovf_d = ovf_q;
    if (st_en_i && sel && (off == OFF_CTRL)) en_d = st_data_i[0];
    if (push_req && !push_acc) begin
      ovf_d = 1'b1;
    end else if (st_en_i && sel && (off == OFF_STATUS) && st_data_i[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
  end

  // Load data mux, purely combinational from the address
  always_comb begin
    ld_data_o = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: begin
          ld_data_o[STAT_BUSY]          = (state_q != IDLE);
          ld_data_o[STAT_FULL]          = fifo_full;
          ld_data_o[STAT_EMPTY]         = fifo_empty;
          ld_data_o[STAT_OVF]           = ovf_q;
          ld_data_o[STAT_CNT_LSB +: 8] = 8'(fifo_count);
        end
        OFF_CTRL: ld_data_o[0] = en_q;
        default:  ld_data_o = '0;
      endcase
    end
  end

  // Transmit FSM next-state, baud/bit counters and registered line value
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          cnt_d = '0;
          // Chain straight into the next frame when more bytes are waiting
          if (en_q && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so uart_tx_o stays registered
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q    <= 1'b1;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx_o = tx_q;
  assign tx_done_o = (state_q == STOP) && bit_last;

endmodule

// File: tb/tb_lsu_uart_tx.sv
// Bench for lsu_uart_tx: register table, directed frame sequences, and a random
// phase, all checked against a frame-level reference model.
module tb_lsu_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_en;
  logic [31:0] addr, st_data, ld_data;
  logic        uart, done;

  always #5 clk = ~clk;

  lsu_uart_tx #(
    .BASE_ADDR    (32'h0000_7040),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .st_en_i   (st_en),
    .addr_i    (addr),
    .st_data_i (st_data),
    .ld_data_o (ld_data),
    .uart_tx_o (uart),
    .tx_done_o (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mt = 0;          // index of the current cycle (edges seen by the model)
  int done_cnt = 0;
  int last_done = -1;

  // Reference model: queued bytes plus the frame currently on the line
  logic [7:0] m_q[$];
  logic       m_en  = 1'b1;
  logic       m_ovf = 1'b0;
  logic       m_act = 1'b0;
  logic [7:0] m_byte = 8'h0;
  int         m_fst = 0;

  typedef struct {
    logic        en;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] want;
  } vec_t;
  vec_t tab[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, mt);
    end
  endtask

  function automatic logic m_line();
    int p, k;
    if (!m_act) return 1'b1;
    p = mt - m_fst;
    k = p / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic m_done();
    return m_act && ((mt - m_fst) == FRAME - 1);
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a[31:4] != 28'h0000704) return v;
    if (a[3:2] == 2'd1) begin
      v[15:8] = 8'(m_q.size());
      v[3] = m_ovf;
      v[2] = (m_q.size() == 0);
      v[1] = (m_q.size() == DEPTH);
      v[0] = m_act;
    end else if (a[3:2] == 2'd2) begin
      v[0] = m_en;
    end
    return v;
  endfunction

  task automatic m_edge(input logic r, input logic e, input logic [31:0] a,
                        input logic [31:0] d);
    logic sel, ending, pop, preq, acc;
    if (r) begin
      m_q.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
      m_en  = 1'b1;
      mt++;
      return;
    end
    sel    = (a[31:4] == 28'h0000704);
    ending = m_act && ((mt - m_fst) == FRAME - 1);
    pop    = m_en && (m_q.size() > 0) && (!m_act || ending);
    preq   = e && sel && (a[3:2] == 2'd0);
    acc    = preq && ((m_q.size() < DEPTH) || pop);
    if (pop) begin
      m_byte = m_q.pop_front();
      m_fst  = mt + 1;
      m_act  = 1'b1;
    end else if (ending) begin
      m_act = 1'b0;
    end
    if (acc) m_q.push_back(d[7:0]);
    else if (preq) m_ovf = 1'b1;
    if (e && sel && (a[3:2] == 2'd1) && d[3]) m_ovf = 1'b0;
    if (e && sel && (a[3:2] == 2'd2)) m_en = d[0];
    mt++;
  endtask

  // One bus cycle: drive, check load data, clock, check line outputs
  task automatic step(input logic e, input logic [31:0] a, input logic [31:0] d);
    st_en = e;
    addr = a;
    st_data = d;
    #1;
    chk("ld_model", ld_data, m_ld(a));
    @(posedge clk);
    m_edge(rst, e, a, d);
    #1;
    chk("uart_line", uart, m_line());
    chk("tx_done", done, m_done());
    if (done === 1'b1) begin
      done_cnt++;
      last_done = mt;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] want, input string nm);
    st_en = 1'b0;
    addr = a;
    #1;
    chk(nm, ld_data, want);
    step(1'b0, a, 32'h0);
  endtask

  task automatic run_to(input int target);
    while (mt < target) step(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, x, r;
    tab[0]  = '{1'b0, 32'h7044, 32'h0,  32'h4};
    tab[1]  = '{1'b0, 32'h7048, 32'h0,  32'h1};
    tab[2]  = '{1'b0, 32'h7040, 32'h0,  32'h0};
    tab[3]  = '{1'b0, 32'h704C, 32'h0,  32'h0};
    tab[4]  = '{1'b1, 32'h7050, 32'hAB, 32'h0};
    tab[5]  = '{1'b0, 32'h7044, 32'h0,  32'h4};
    tab[6]  = '{1'b1, 32'h704C, 32'hFF, 32'h0};
    tab[7]  = '{1'b0, 32'h7044, 32'h0,  32'h4};
    tab[8]  = '{1'b1, 32'h7048, 32'h0,  32'h1};
    tab[9]  = '{1'b0, 32'h7048, 32'h0,  32'h0};
    tab[10] = '{1'b1, 32'h7048, 32'h1,  32'h0};
    tab[11] = '{1'b0, 32'h7048, 32'h0,  32'h1};
    tab[12] = '{1'b0, 32'h8044, 32'h0,  32'h0};
    tab[13] = '{1'b0, 32'h7054, 32'h0,  32'h0};

    rst = 1'b1;
    st_en = 1'b0;
    addr = 32'h0;
    st_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_uart", uart, 1'b1);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;

    // Register map table
    foreach (tab[i]) begin
      st_en = tab[i].en;
      addr = tab[i].a;
      st_data = tab[i].d;
      #1;
      chk($sformatf("tab_ld[%0d]", i), ld_data, tab[i].want);
      step(tab[i].en, tab[i].a, tab[i].d);
    end

    // Single 0x55 frame
    done_cnt = 0;
    step(1'b1, 32'h7040, 32'h55);
    e = mt;
    chk("s1_idle_at_push", uart, 1'b1);
    step(1'b0, 32'h0, 32'h0);
    chk("s1_start_low", uart, 1'b0);
    run_to(e + 5);
    chk("s1_bit0", uart, 1'b1);
    run_to(e + 9);
    chk("s1_bit1", uart, 1'b0);
    run_to(e + 37);
    chk("s1_stop", uart, 1'b1);
    run_to(e + 45);
    chk("s1_done_count", done_cnt, 1);
    chk("s1_done_cycle", last_done, e + 40);
    rd(32'h7044, 32'h4, "s1_status_idle");

    // Overflow and back-to-back frames
    done_cnt = 0;
    for (int i = 1; i <= 6; i++) step(1'b1, 32'h7040, i);
    e = mt - 5;
    rd(32'h7044, 32'h0000_040B, "s2_status_full_ovf");
    run_to(e + 205);
    chk("s2_done_count", done_cnt, 5);
    chk("s2_last_done", last_done, e + 200);
    rd(32'h7044, 32'h0000_000C, "s2_status_ovf_sticky");
    step(1'b1, 32'h7044, 32'h8);
    rd(32'h7044, 32'h4, "s2_ovf_cleared");

    // Disable mid-frame with a byte queued
    done_cnt = 0;
    step(1'b1, 32'h7040, 32'hA3);
    e = mt;
    step(1'b1, 32'h7040, 32'h3C);
    run_to(e + 10);
    step(1'b1, 32'h7048, 32'h0);
    run_to(e + 60);
    chk("s3_done_count", done_cnt, 1);
    chk("s3_done_cycle", last_done, e + 40);
    chk("s3_line_idle", uart, 1'b1);
    rd(32'h7044, 32'h0000_0100, "s3_status_held");
    step(1'b1, 32'h7048, 32'h1);
    x = mt;
    chk("s3_idle_at_enable", uart, 1'b1);
    step(1'b0, 32'h0, 32'h0);
    chk("s3_restart_low", uart, 1'b0);
    run_to(x + 45);

    // Reset in the middle of a data bit
    done_cnt = 0;
    step(1'b1, 32'h7040, 32'h11);
    e = mt;
    step(1'b1, 32'h7040, 32'h22);
    step(1'b1, 32'h7040, 32'h33);
    run_to(e + 12);
    rst = 1'b1;
    step(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    chk("s4_line_after_reset", uart, 1'b1);
    rd(32'h7044, 32'h4, "s4_status_after_reset");
    run_to(mt + 60);
    chk("s4_no_done", done_cnt, 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        step(1'b1, 32'h7040 | $urandom_range(0, 3), $urandom);
      end else if (r < 9) begin
        step(1'b1, 32'h7044, $urandom);
      end else if (r < 11) begin
        step(1'b1, 32'h7048, {31'h0, ($urandom_range(0, 3) != 0)});
      end else if (r < 13) begin
        step(1'b1, $urandom, $urandom);
      end else if (r < 14) begin
        rst = 1'b1;
        step(1'b0, 32'h0, 32'h0);
        rst = 1'b0;
      end else if (r < 40) begin
        step(1'b0, 32'h7040 + 4 * $urandom_range(0, 3), 32'h0);
      end else begin
        step(1'b0, 32'h0, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
